mem_io_arbiter: RTL and testbench
=================================

// Module: mem_io_arbiter
// PURPOSE
//  Shares the single data-memory / memory-mapped-IO port between two requesters: CPU data port (port 0)
//  and UART program loader (port 1). Round-robin arbitration, address decode into memory / LED / switch,
//  fixed 2-cycle req->ack transaction, registered read data. Sits between the requesters and the data RAM + IO.
// PARAMETERS
//  DATA_W     32       data width of all data buses
//  IO_BASE_HI 22'h3FFFFF  addr[31:10] value selecting the IO region (0xFFFFFC00-0xFFFFFFFF)
//  LED_OFFS   4'h6     addr[7:4] selecting LED (0xFFFFFC60)
//  SW_OFFS    4'h7     addr[7:4] selecting switches (0xFFFFFC70)
// PORTS
//  clock       in   1   system clock, rising edge
//  reset_n     in   1   asynchronous active-low reset
//  req[1:0]    in   2   request per port (0=CPU, 1=loader)
//  we[1:0]     in   2   1=write, 0=read, per port
//  addr0/addr1 in   32  byte address per port
//  wdata0/wdata1 in DATA_W write data per port
//  ack[1:0]    out  2   one-cycle completion pulse per port
//  err         out  1   one-cycle pulse with ack: unmapped IO address
//  rdata       out  DATA_W  registered read data, valid in the ack cycle
//  mem_en      out  1   RAM enable
//  mem_we      out  1   RAM write enable
//  mem_addr    out  32  RAM byte address
//  mem_wdata   out  DATA_W RAM write data
//  mem_rdata   in   DATA_W RAM read data, 1-cycle synchronous latency
//  led_cs      out  1   LED chip select (active high, qualifies io_we)
//  sw_cs       out  1   switch chip select (active high)
//  io_we       out  1   IO write strobe
//  io_wdata    out  DATA_W IO write data
//  io_rdata    in   DATA_W switch read data, combinational
// BEHAVIOUR
//  Reset: state=IDLE, last_gnt=1 (CPU wins first tie), all outputs 0, rdata=0. Async assert, sync release.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if |req, latch winner (gnt), its we/addr/wdata into internal regs; go ACCESS. Else stay.
//   ACCESS: drive downstream from latched regs for exactly one cycle:
//    mem region (addr[31:10]!=IO_BASE_HI): mem_en=1, mem_we=we.
//    IO LED: led_cs=1, io_we=we. IO switch: sw_cs=1 (writes to switch ignored, still acked).
//    IO other offset: no strobe, flag err for RESP.
//    mem_addr/mem_wdata/io_wdata driven from latched regs; zero when not ACCESS.
//   RESP: ack[gnt]=1; rdata <= mem_rdata (mem read), io_rdata sampled in ACCESS (switch read),
//    0 for writes/err; err=1 if flagged. Next cycle IDLE.
//  Latency: req sampled at edge N -> ACCESS cycle N+1 -> ack/rdata valid cycle N+2. Max 1 txn / 3 cycles.
//  Arbitration: single req -> grant it. Both -> grant port != last_gnt; last_gnt updated on grant.
//  Handshake: requester holds req/we/addr/wdata until ack; inputs only sampled in IDLE. Req kept
//   high after ack = new transaction, re-arbitrated. Req dropped before ack: txn still completes, ack pulses.
//  At most one ack bit high; downstream strobes never overlap (mem_en, led_cs, sw_cs mutually exclusive).
//  Reset mid-transaction: abort immediately, no ack, no further strobes; RAM write of the ACCESS
//   cycle may or may not have landed.
//  Address bits [1:0] passed through unchanged; alignment is the requester's responsibility.
// STRUCTURE
//  Shared package mem_io_pkg: IO_BASE_HI, LED_OFFS, SW_OFFS, FSM state encoding (IDLE/ACCESS/RESP),
//   region enum (REG_MEM/REG_LED/REG_SW/REG_BAD); reused by CPU decoder and loader.
//  One sub-module: mem_io_decode (combinational addr -> region), instantiated on the latched address.
// TESTING
//  CPU write 0x0000_0010 <= 0xDEADBEEF then read -> ACCESS mem_en=1 mem_we=1; read ack at N+2, rdata=0xDEADBEEF.
//  CPU write 0xFFFFFC60 <= 0x0000_00A5 -> led_cs=1 io_we=1 io_wdata=0xA5 for one cycle, ack[0], err=0.
//  Loader read 0xFFFFFC70, io_rdata=0x0000_1234 -> sw_cs=1, ack[1] with rdata=0x1234.
//  req=2'b11 held 4 txns from reset -> grant order CPU, loader, CPU, loader; never two acks in a cycle.
//  CPU read 0xFFFFFC80 -> no strobes, ack[0] with err=1, rdata=0.
//  reset_n low during ACCESS -> all outputs 0 next edge, no ack; after release, pending req served normally.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared definitions for the data-memory / memory-mapped-IO port.
// Holds the IO address map, the transaction FSM state encoding, the
// address-region enum and the round-robin pick used by mem_io_arbiter.
package mem_io_pkg;

  // addr[31:10] value of the IO page (0xFFFFFC00-0xFFFFFFFF)
  localparam logic [21:0] IO_BASE_HI = 22'h3FFFFF;
  // addr[7:4] offsets inside the IO page
  localparam logic [3:0]  LED_OFFS   = 4'h6;
  localparam logic [3:0]  SW_OFFS    = 4'h7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_MEM = 2'd0,
    REG_LED = 2'd1,
    REG_SW  = 2'd2,
    REG_BAD = 2'd3
  } region_t;

  // Port to grant: a lone requester wins; on a tie the port that was not
  // granted last time wins. Result is meaningless when req == 0.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
    if (req == 2'b11) begin
      return ~last_gnt;
    end
    return req[1];
  endfunction

endpackage

// File: rtl/mem_io_decode.sv
// Address decoder for the shared memory / IO port.
// Ports:
//   page   in  22  addr[31:10] of the access
//   offs   in  4   addr[7:4] of the access
//   region out     REG_MEM outside the IO page, otherwise REG_LED / REG_SW
//                  for the mapped offsets and REG_BAD for anything else
// addr[9:8] and addr[3:0] do not take part in IO decoding.
module mem_io_decode #(
  parameter logic [21:0] IO_BASE_HI = mem_io_pkg::IO_BASE_HI,
  parameter logic [3:0]  LED_OFFS   = mem_io_pkg::LED_OFFS,
  parameter logic [3:0]  SW_OFFS    = mem_io_pkg::SW_OFFS
) (
  input  logic [21:0]         page,
  input  logic [3:0]          offs,
  output mem_io_pkg::region_t region
);
  import mem_io_pkg::*;

  always_comb begin
    region = REG_MEM;
    if (page == IO_BASE_HI) begin
      if (offs == LED_OFFS) begin
        region = REG_LED;
      end else if (offs == SW_OFFS) begin
        region = REG_SW;
      end else begin
        region = REG_BAD;
      end
    end
  end

endmodule

// File: rtl/mem_io_arbiter.sv
// Two-port arbiter in front of the data RAM and memory-mapped IO.
// Port 0 is the CPU data port, port 1 the UART program loader. Each
// transaction is IDLE (arbitrate + latch) -> ACCESS (one downstream strobe
// cycle) -> RESP (ack pulse, read data valid).
// Ports:
//   clock, reset_n           clock (rising edge), async active-low reset
//   req, we                  per-port request / write flag
//   addr0/1, wdata0/1        per-port byte address and write data
//   ack, err                 one-cycle completion pulse per port, unmapped-IO flag
//   rdata                    read data, valid in the ack cycle
//   mem_en/we/addr/wdata     RAM strobe and bus, mem_rdata 1-cycle latency
//   led_cs, sw_cs, io_we     IO chip selects and write strobe
//   io_wdata, io_rdata       IO write data, combinational switch read data
module mem_io_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter logic [21:0] IO_BASE_HI = mem_io_pkg::IO_BASE_HI,
  parameter logic [3:0]  LED_OFFS   = mem_io_pkg::LED_OFFS,
  parameter logic [3:0]  SW_OFFS    = mem_io_pkg::SW_OFFS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              led_cs,
  output logic              sw_cs,
  output logic              io_we,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);
  import mem_io_pkg::*;

  state_t            state, state_nxt;
  region_t           region;
  logic              win;
  logic              gnt;
  logic              last_gnt;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_read;

  assign win      = rr_pick(req, last_gnt);
  assign mem_read = !l_we && (region == REG_MEM);

  mem_io_decode #(
    .IO_BASE_HI (IO_BASE_HI),
    .LED_OFFS   (LED_OFFS),
    .SW_OFFS    (SW_OFFS)
  ) u_decode (
    .page   (l_addr[31:10]),
    .offs   (l_addr[7:4]),
    .region (region)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch and read-data holding register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt      <= win;
            last_gnt <= win;
            l_we     <= we[win];
            l_addr   <= win ? addr1 : addr0;
            l_wdata  <= win ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          rdata_q <= (!l_we && (region == REG_SW)) ? io_rdata : '0;
        end
        RESP: begin
          if (mem_read) begin
            rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // The RAM's own output register supplies memory read data during RESP, so
  // rdata forwards mem_rdata in that cycle and rdata_q keeps it afterwards.
  always_comb begin
    state_nxt = state;
    ack       = '0;
    err       = 1'b0;
    rdata     = rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    led_cs    = 1'b0;
    sw_cs     = 1'b0;
    io_we     = 1'b0;
    io_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        mem_addr  = l_addr;
        mem_wdata = l_wdata;
        io_wdata  = l_wdata;
        mem_en    = (region == REG_MEM);
        mem_we    = (region == REG_MEM) && l_we;
        led_cs    = (region == REG_LED);
        io_we     = (region == REG_LED) && l_we;
        sw_cs     = (region == REG_SW);
      end
      RESP: begin
        state_nxt = IDLE;
        ack[gnt]  = 1'b1;
        err       = (region == REG_BAD);
        if (mem_read) begin
          rdata = mem_rdata;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Self-checking bench for mem_io_arbiter: directed scenarios followed by
// randomized two-requester traffic, checked every cycle against a
// transaction-level reference model.
module tb_mem_io_arbiter;

  localparam int R_MEM = 0;
  localparam int R_LED = 1;
  localparam int R_SW  = 2;
  localparam int R_BAD = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        led_cs, sw_cs, io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = '0;

  always #5 clock = ~clock;

  mem_io_arbiter #(.DATA_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .led_cs    (led_cs),
    .sw_cs     (sw_cs),
    .io_we     (io_we),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata)
  );

  // Synchronous RAM seen by the DUT; bench addresses are distinct in addr[7:0].
  logic [31:0] ram_env [256] = '{default: '0};
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram_env[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram_env[mem_addr[7:0]];
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester side
  txn_t       q0[$], q1[$];
  txn_t       cur[2];
  bit         busy[2];
  logic [1:0] rq = '0;
  bit         directed = 1'b1;
  int         gl[$];
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  // Reference model state
  int unsigned cyc = 0;
  int unsigned m_ts = 0;
  int unsigned m_next = 0;
  bit          m_active = 1'b0;
  int          m_gnt = 0;
  bit          m_last = 1'b1;
  txn_t        m_t;
  logic [31:0] m_sw = '0;
  logic [31:0] model_mem [logic [31:0]];

  logic [31:0] mem_pool [10] = '{32'h140, 32'h144, 32'h148, 32'h14C, 32'h150,
                                 32'h154, 32'h158, 32'h15C, 32'h142, 32'hFFFFFBF8};
  logic [3:0]  bad_offs [5] = '{4'h0, 4'h1, 4'h5, 4'h8, 4'hF};

  function automatic int classify(input logic [31:0] a);
    if (a[31:10] != 22'h3FFFFF) return R_MEM;
    if (a[7:4] == 4'h6) return R_LED;
    if (a[7:4] == 4'h7) return R_SW;
    return R_BAD;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int unsigned sel;
    sel     = $urandom_range(9);
    t.we    = 1'($urandom_range(1));
    t.wdata = $urandom;
    case (sel)
      5:       t.addr = ($urandom_range(1) != 0) ? 32'hFFFFFC60 : 32'hFFFFFE64;
      6:       t.addr = 32'hFFFFFC70;
      7:       t.addr = {24'hFFFFFC, bad_offs[$urandom_range(4)], 4'h0};
      default: t.addr = mem_pool[$urandom_range(9)];
    endcase
    return t;
  endfunction

  task automatic push(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (!busy[p]) begin
        rq[p] = 1'b0;
        if (((p == 0) ? q0.size() : q1.size()) > 0 && (directed || $urandom_range(3) != 0)) begin
          if (p == 0) cur[0] = q0.pop_front();
          else        cur[1] = q1.pop_front();
          busy[p] = 1'b1;
          rq[p]   = 1'b1;
        end
      end else if (!directed && rq[p] && m_active && m_gnt == p && $urandom_range(3) == 0) begin
        rq[p] = 1'b0;  // drop request after it was taken; ack must still come
      end
    end
    req      = rq;
    we       = {cur[1].we, cur[0].we};
    addr0    = cur[0].addr;
    addr1    = cur[1].addr;
    wdata0   = cur[0].wdata;
    wdata1   = cur[1].wdata;
    io_rdata = directed ? 32'h0000_1234 : $urandom;
  endtask

  task automatic model_edge();
    int w;
    if (cyc >= m_next && req != 2'b00) begin
      w        = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
      m_last   = (w == 1);
      m_gnt    = w;
      m_t      = cur[w];
      m_ts     = cyc;
      m_next   = cyc + 3;
      m_active = 1'b1;
    end else if (m_active && cyc == m_ts + 1) begin
      m_sw = io_rdata;
    end
  endtask

  task automatic check_cycle();
    int          r;
    bit          in_acc, in_resp;
    logic [31:0] e_str, e_ma, e_wd, e_rd;
    in_acc  = m_active && (cyc == m_ts);
    in_resp = m_active && (cyc == m_ts + 1);
    r       = classify(m_t.addr);
    e_str   = '0;
    e_ma    = '0;
    e_wd    = '0;
    if (in_acc) begin
      e_str[4] = (r == R_MEM);
      e_str[3] = (r == R_MEM) && m_t.we;
      e_str[2] = (r == R_LED);
      e_str[1] = (r == R_SW);
      e_str[0] = (r == R_LED) && m_t.we;
      e_ma     = m_t.addr;
      e_wd     = m_t.wdata;
      if (r == R_MEM && m_t.we) model_mem[m_t.addr] = m_t.wdata;
    end
    if (in_resp) begin
      e_str[6 + m_gnt] = 1'b1;
      e_str[5]         = (r == R_BAD);
    end
    check_eq("strobes", {24'h0, ack, err, mem_en, mem_we, led_cs, sw_cs, io_we}, e_str);
    check_eq("mem_addr", mem_addr, e_ma);
    check_eq("mem_wdata", mem_wdata, e_wd);
    check_eq("io_wdata", io_wdata, e_wd);
    if (in_resp) begin
      e_rd = '0;
      if (!m_t.we && r == R_MEM) e_rd = model_mem.exists(m_t.addr) ? model_mem[m_t.addr] : '0;
      if (!m_t.we && r == R_SW)  e_rd = m_sw;
      check_eq("rdata", rdata, e_rd);
      m_active = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (ack[p]) begin
        busy[p] = 1'b0;
        gl.push_back(p);
      end
    end
    if (ack != 2'b00) begin
      last_rdata = rdata;
      last_err   = err;
    end
  endtask

  task automatic step();
    @(negedge clock);
    drive();
    @(posedge clock);
    cyc++;
    model_edge();
    #1 check_cycle();
  endtask

  task automatic run_until_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy[0] || busy[1]) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain", q0.size() + q1.size() + int'(busy[0]) + int'(busy[1]), 0);
    repeat (3) step();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_strobes"}, {24'h0, ack, err, mem_en, mem_we, led_cs, sw_cs, io_we}, '0);
    check_eq({tag, "_mem_addr"}, mem_addr, '0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
    check_eq({tag, "_io_wdata"}, io_wdata, '0);
    check_eq({tag, "_rdata"}, rdata, '0);
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = 1'b1;
    m_next   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    cur[0] = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    cur[1] = '{we: 1'b0, addr: 32'h0, wdata: 32'h0};
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_zero("reset");
    reset_n = 1'b1;
    model_reset();

    // Tie from reset: CPU first, then alternation.
    gl.delete();
    push(0, 1'b1, 32'h140, 32'h1111_0000);
    push(0, 1'b0, 32'h140, 32'h0);
    push(1, 1'b1, 32'h144, 32'h2222_0000);
    push(1, 1'b0, 32'h144, 32'h0);
    run_until_idle(60);
    check_eq("gnt_count", gl.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("gnt_order%0d", i), (gl.size() > i) ? gl[i] : -1, i % 2);
    end

    push(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF);
    push(0, 1'b0, 32'h0000_0010, 32'h0);
    run_until_idle(40);
    check_eq("dead_rd", last_rdata, 32'hDEADBEEF);

    push(0, 1'b1, 32'hFFFFFC60, 32'h0000_00A5);
    run_until_idle(40);
    check_eq("led_err", last_err, 1'b0);

    push(1, 1'b0, 32'hFFFFFC70, 32'h0);
    run_until_idle(40);
    check_eq("sw_rd", last_rdata, 32'h0000_1234);

    push(0, 1'b0, 32'hFFFFFC80, 32'h0);
    run_until_idle(40);
    check_eq("bad_err", last_err, 1'b1);
    check_eq("bad_rd", last_rdata, 32'h0);

    // Reset while a RAM write is in its ACCESS cycle.
    push(0, 1'b1, 32'h148, 32'h5555_AAAA);
    n = 0;
    while (!(m_active && cyc == m_ts) && n < 20) begin
      step();
      n++;
    end
    check_eq("rst_reach", 32'(m_active && cyc == m_ts), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clock);
    #1 check_zero("rst_hold");
    reset_n = 1'b1;
    model_reset();
    run_until_idle(40);
    push(1, 1'b0, 32'h148, 32'h0);
    run_until_idle(40);
    check_eq("rst_wr_rd", last_rdata, 32'h5555_AAAA);

    // Random traffic from both requesters.
    directed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(1) != 0) q0.push_back(rand_txn());
      else                        q1.push_back(rand_txn());
    end
    run_until_idle(5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
